mux4_sel_arbiter: RTL and testbench

MUX4_SEL_ARBITER -- requirements
Module: mux4_sel_arbiter

---
 rtl/mux4_sel_arbiter.sv | 105 ++++++++++
 tb/tb_mux4_sel_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_sel_arbiter.sv
// Four-input mux select arbiter: round-robin with bounded bursts, one beat per
// grant, and a select that stays parked on the last granted channel.
module mux4_sel_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       out_ready,
   output logic       s0,
   output logic       s1,
   output logic       out_valid,
   output logic [3:0] gnt,
   output logic [3:0] ack
);

   localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     r_state, w_nextState;
   logic [3:0] r_gnt, w_nextGnt;
   logic [1:0] r_sel, w_nextSel;
   logic [1:0] r_last, w_nextLast;
   logic [3:0] r_burstCnt, w_nextBurstCnt;
   logic [1:0] w_rrWinner;
   logic [1:0] w_winner;
   logic       w_burstHold;
   logic       w_accept;

   // Descending scan so the nearest channel after r_last overwrites the others.
   always_comb begin
      w_rrWinner = r_last;
      for (int k = 4; k >= 1; k--) begin
         if (req[r_last + 2'(k)]) begin
            w_rrWinner = r_last + 2'(k);
         end
      end
   end

   // A zero count means no burst is in progress, so reset (last=3) never lets
   // channel 3 jump ahead of channel 0.
   assign w_burstHold = req[r_last] && (r_burstCnt != 4'd0) && (r_burstCnt < BURST_LIMIT);
   assign w_winner    = w_burstHold ? r_last : w_rrWinner;
   assign w_accept    = out_ready && req[r_sel];

   always_comb begin
      w_nextState    = r_state;
      w_nextGnt      = r_gnt;
      w_nextSel      = r_sel;
      w_nextLast     = r_last;
      w_nextBurstCnt = r_burstCnt;
      case (r_state)
         IDLE: begin
            if (req != 4'b0000) begin
               w_nextState = GRANT;
               w_nextGnt   = 4'b0001 << w_winner;
               w_nextSel   = w_winner;
               if (w_winner != r_last) begin
                  w_nextBurstCnt = 4'd0;
               end
            end
         end
         GRANT: begin
            if (!req[r_sel]) begin
               w_nextState    = IDLE;
               w_nextGnt      = 4'b0000;
               w_nextLast     = r_sel;
               w_nextBurstCnt = 4'd0;
            end else if (out_ready) begin
               w_nextState    = IDLE;
               w_nextGnt      = 4'b0000;
               w_nextLast     = r_sel;
               w_nextBurstCnt = (r_burstCnt >= BURST_LIMIT) ? r_burstCnt : r_burstCnt + 4'd1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gnt      <= 4'b0000;
         r_sel      <= 2'd0;
         r_last     <= 2'd3;
         r_burstCnt <= 4'd0;
      end else begin
         r_state    <= w_nextState;
         r_gnt      <= w_nextGnt;
         r_sel      <= w_nextSel;
         r_last     <= w_nextLast;
         r_burstCnt <= w_nextBurstCnt;
      end
   end

   assign s0        = r_sel[0];
   assign s1        = r_sel[1];
   assign out_valid = (r_state == GRANT);
   assign gnt       = r_gnt;
   assign ack       = (rst_n && (r_state == GRANT) && w_accept) ? r_gnt : 4'b0000;

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Bench for mux4_sel_arbiter: two instances (MAX_BURST 4 and 1) on shared inputs,
// checked against a rule-level model, a directed vector table and sequences.
module tb_mux4_sel_arbiter;

   logic       clk;
   logic       tbRstN;
   logic [3:0] tbReq;
   logic       tbRdy;

   logic       s0A, s1A, validA, s0B, s1B, validB;
   logic [3:0] gntA, ackA, gntB, ackB;

   int errCount;
   int checkCount;

   int mBusy[2];
   int mG[2];
   int mLast[2];
   int mBurst[2];
   int mSel[2];
   int maxB[2];

   typedef struct {
      logic       rstn;
      logic [3:0] req;
      logic       rdy;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[20];

   mux4_sel_arbiter #(.MAX_BURST(4)) dutA (
      .clk(clk), .rst_n(tbRstN), .req(tbReq), .out_ready(tbRdy),
      .s0(s0A), .s1(s1A), .out_valid(validA), .gnt(gntA), .ack(ackA)
   );

   mux4_sel_arbiter #(.MAX_BURST(1)) dutB (
      .clk(clk), .rst_n(tbRstN), .req(tbReq), .out_ready(tbRdy),
      .s0(s0B), .s1(s1B), .out_valid(validB), .gnt(gntB), .ack(ackB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] pack(logic v, logic [3:0] g, logic [1:0] s, logic [3:0] a);
      return {v, g, s, a};
   endfunction

   // Expected outputs follow from the model state plus this cycle's inputs (ack is combinational).
   function automatic logic [10:0] modelOut(int m);
      logic [3:0] g;
      logic [3:0] a;
      g = (mBusy[m] != 0) ? 4'(1 << mG[m]) : 4'b0000;
      a = (tbRstN && mBusy[m] != 0 && tbRdy && tbReq[mG[m]]) ? g : 4'b0000;
      return pack(mBusy[m] != 0, g, 2'(mSel[m]), a);
   endfunction

   task automatic modelStep();
      int w;
      for (int m = 0; m < 2; m++) begin
         if (!tbRstN) begin
            mBusy[m] = 0; mG[m] = 0; mSel[m] = 0; mLast[m] = 3; mBurst[m] = 0;
         end else if (mBusy[m] == 0) begin
            if (tbReq != 4'b0000) begin
               w = -1;
               if (tbReq[mLast[m]] && mBurst[m] > 0 && mBurst[m] < maxB[m]) w = mLast[m];
               for (int k = 1; k <= 4; k++)
                  if (w < 0 && tbReq[(mLast[m] + k) % 4]) w = (mLast[m] + k) % 4;
               if (w != mLast[m]) mBurst[m] = 0;
               mBusy[m] = 1; mG[m] = w; mSel[m] = w;
            end
         end else if (!tbReq[mG[m]]) begin
            mBusy[m] = 0; mLast[m] = mG[m]; mBurst[m] = 0;
         end else if (tbRdy) begin
            mBusy[m] = 0; mLast[m] = mG[m]; mBurst[m] = mBurst[m] + 1;
         end
      end
   endtask

   task automatic checkOutput(string name, logic [10:0] act, logic [10:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got valid=%b gnt=%b sel=%b ack=%b, want valid=%b gnt=%b sel=%b ack=%b",
                  name, act[10], act[9:6], act[5:4], act[3:0], exp[10], exp[9:6], exp[5:4], exp[3:0]);
      end
   endtask

   // Drive inputs, move to the falling edge, and compare both instances with the model.
   task automatic applyStimulus(logic r, logic [3:0] q, logic y, string tag);
      tbRstN = r; tbReq = q; tbRdy = y;
      @(negedge clk);
      checkOutput($sformatf("%s model A", tag), pack(validA, gntA, {s1A, s0A}, ackA), modelOut(0));
      checkOutput($sformatf("%s model B", tag), pack(validB, gntB, {s1B, s0B}, ackB), modelOut(1));
   endtask

   task automatic advance();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   initial begin
      logic [10:0] actA;
      logic [10:0] actB;
      int rrOrder[5];
      int burstOrder[9];
      logic [3:0] q;

      errCount = 0; checkCount = 0;
      maxB[0] = 4; maxB[1] = 1;
      for (int m = 0; m < 2; m++) begin
         mBusy[m] = 0; mG[m] = 0; mSel[m] = 0; mLast[m] = 3; mBurst[m] = 0;
      end

      vecs[0]  = '{1'b0, 4'b1111, 1'b1, pack(0, 4'b0000, 2'd0, 4'b0000)};
      vecs[1]  = '{1'b1, 4'b1111, 1'b1, pack(0, 4'b0000, 2'd0, 4'b0000)};
      vecs[2]  = '{1'b1, 4'b1111, 1'b1, pack(1, 4'b0001, 2'd0, 4'b0001)};
      vecs[3]  = '{1'b1, 4'b1000, 1'b0, pack(0, 4'b0000, 2'd0, 4'b0000)};
      for (int i = 4; i <= 8; i++)
         vecs[i] = '{1'b1, 4'b1000, 1'b0, pack(1, 4'b1000, 2'd3, 4'b0000)};
      vecs[9]  = '{1'b1, 4'b1000, 1'b1, pack(1, 4'b1000, 2'd3, 4'b1000)};
      vecs[10] = '{1'b1, 4'b0000, 1'b0, pack(0, 4'b0000, 2'd3, 4'b0000)};
      vecs[11] = '{1'b1, 4'b0010, 1'b0, pack(0, 4'b0000, 2'd3, 4'b0000)};
      vecs[12] = '{1'b1, 4'b0110, 1'b0, pack(1, 4'b0010, 2'd1, 4'b0000)};
      vecs[13] = '{1'b1, 4'b0100, 1'b0, pack(1, 4'b0010, 2'd1, 4'b0000)};
      vecs[14] = '{1'b1, 4'b0100, 1'b1, pack(0, 4'b0000, 2'd1, 4'b0000)};
      vecs[15] = '{1'b1, 4'b0100, 1'b0, pack(1, 4'b0100, 2'd2, 4'b0000)};
      vecs[16] = '{1'b0, 4'b0100, 1'b1, pack(1, 4'b0100, 2'd2, 4'b0000)};
      vecs[17] = '{1'b1, 4'b0000, 1'b1, pack(0, 4'b0000, 2'd0, 4'b0000)};
      vecs[18] = '{1'b1, 4'b1111, 1'b1, pack(0, 4'b0000, 2'd0, 4'b0000)};
      vecs[19] = '{1'b1, 4'b1111, 1'b1, pack(1, 4'b0001, 2'd0, 4'b0001)};

      // First reset edge: outputs are still unknown, so only the model is updated.
      tbRstN = 1'b0; tbReq = 4'b1111; tbRdy = 1'b1;
      advance();

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].rstn, vecs[i].req, vecs[i].rdy, $sformatf("vec%0d", i));
         actA = pack(validA, gntA, {s1A, s0A}, ackA);
         actB = pack(validB, gntB, {s1B, s0B}, ackB);
         checkOutput($sformatf("vec%0d table A", i), actA, vecs[i].exp);
         checkOutput($sformatf("vec%0d table B", i), actB, vecs[i].exp);
         advance();
      end

      // Round-robin on the MAX_BURST=1 instance: one grant every other cycle.
      rrOrder = '{0, 1, 2, 3, 0};
      applyStimulus(1'b0, 4'b1111, 1'b1, "rr rst");
      advance();
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, 4'b1111, 1'b1, $sformatf("rr%0d", c));
         actB = pack(validB, gntB, {s1B, s0B}, ackB);
         if (c % 2 == 1)
            checkOutput($sformatf("rr%0d order B", c), actB,
                        pack(1, 4'(1 << rrOrder[c / 2]), 2'(rrOrder[c / 2]), 4'(1 << rrOrder[c / 2])));
         else
            checkOutput($sformatf("rr%0d idle B", c), actB,
                        pack(0, 4'b0000, 2'(c == 0 ? 0 : rrOrder[c / 2 - 1]), 4'b0000));
         advance();
      end

      // Burst on the MAX_BURST=4 instance: four beats on ch1, four on ch2, then ch1.
      burstOrder = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
      applyStimulus(1'b0, 4'b0110, 1'b1, "burst rst");
      advance();
      for (int c = 0; c < 18; c++) begin
         applyStimulus(1'b1, 4'b0110, 1'b1, $sformatf("burst%0d", c));
         if (c % 2 == 1)
            checkOutput($sformatf("burst%0d ack A", c), pack(validA, gntA, {s1A, s0A}, ackA),
                        pack(1, 4'(1 << burstOrder[c / 2]), 2'(burstOrder[c / 2]),
                             4'(1 << burstOrder[c / 2])));
         advance();
      end

      // Random traffic with sticky requests so bursts and backpressure both occur.
      q = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 9) < 3) q = 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, q,
                       ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, $sformatf("rnd%0d", c));
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
